// File: rtl/aes_decryption_if.sv
// Bus bundle for the iterative AES inverse cipher: input FIFO pop side, key-schedule store
// read port and output buffer write side.
interface aes_decryption_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              read_fifo;
    logic [127:0]      fifo_in;
    logic              fifo_ack;
    logic [127:0]      round_key_last;
    logic [ADDR_W-1:0] round_key_addr;
    logic [127:0]      round_key_input;
    logic              is_full;
    logic [127:0]      data_output;
    logic              data_valid;
    logic              busy;

    modport master (
        input  read_fifo, fifo_in, round_key_last, round_key_input, is_full,
        output fifo_ack, round_key_addr, data_output, data_valid, busy
    );

    modport slave (
        output read_fifo, fifo_in, round_key_last, round_key_input, is_full,
        input  fifo_ack, round_key_addr, data_output, data_valid, busy
    );
endinterface

// File: rtl/aes_decryption.sv
// Iterative AES inverse cipher: one 128-bit block in flight, one round per clock, round keys
// fetched highest index first from the shared key-schedule store.
module aes_decryption #(
    parameter int unsigned NR     = 10,
    parameter int unsigned ADDR_W = 5
) (
    input logic              clk,
    input logic              rst,
    aes_decryption_if.master bus
);
    localparam int unsigned RndW = (NR > 2) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} st_e;

    st_e             st_q, st_d;
    logic [RndW-1:0] rnd_q, rnd_d;
    logic [127:0]    data_q, data_d;
    logic [127:0]    isr, isb, ark, imc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse affine map, then GF(2^8) inversion as x^254 (which also maps 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] sq;
        logic [7:0] acc;
        for (int i = 0; i < 8; i++) begin
            a[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8];
        end
        a   = a ^ 8'h05;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    // Byte k of the block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3, row r = k % 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (4 * c + r) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = gmul(a[r], 8'h0e) ^
                                                gmul(a[(r + 1) % 4], 8'h0b) ^
                                                gmul(a[(r + 2) % 4], 8'h0d) ^
                                                gmul(a[(r + 3) % 4], 8'h09);
            end
        end
        return o;
    endfunction

    assign isr = inv_shift_rows(data_q);
    assign isb = inv_sub_bytes(isr);
    assign ark = isb ^ bus.round_key_input;
    assign imc = inv_mix_columns(ark);

    assign bus.data_output = data_q;

    always_comb begin
        st_d               = st_q;
        rnd_d              = rnd_q;
        data_d             = data_q;
        bus.fifo_ack       = 1'b0;
        bus.round_key_addr = '0;
        bus.data_valid     = 1'b0;
        bus.busy           = 1'b1;
        case (st_q)
            StIdle: begin
                bus.busy = 1'b0;
                // Gated by rst so the FIFO head is never popped while the core is held in reset.
                if (bus.read_fifo && !rst) begin
                    bus.fifo_ack = 1'b1;
                    data_d       = bus.fifo_in ^ bus.round_key_last;
                    rnd_d        = RndW'(NR - 1);
                    st_d         = StRound;
                end
            end
            StRound: begin
                bus.round_key_addr = ADDR_W'(rnd_q);
                data_d             = imc;
                if (rnd_q == RndW'(1)) begin
                    rnd_d = '0;
                    st_d  = StFinal;
                end else begin
                    rnd_d = rnd_q - RndW'(1);
                end
            end
            StFinal: begin
                data_d = ark;
                st_d   = StDone;
            end
            StDone: begin
                bus.data_valid = 1'b1;
                if (!bus.is_full) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= StIdle;
            rnd_q  <= '0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
        end
    end
endmodule
